line_buf_pingpong: RTL and testbench

- Parametrised, double-buffered line memory of DEPTH entries × WIDTH bits; next generation of the single-bank 480×1 line RAM.
- Two banks:
  - Front bank: every entry is exposed in parallel to the display/compare logic.
  - Back bank: written by the producer (game/draw logic).
- The banks exchange roles on a swap pulse.
- Adds a sequential hardware clear engine, a registered random-read port, and error flagging for illegal writes.

---
 rtl/line_buf_pkg.sv | 14 +
 rtl/line_buf_bank.sv | 29 ++
 rtl/line_buf_pingpong.sv | 157 +++++++++++++++
 tb/tb_line_buf_pingpong.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/line_buf_pkg.sv
// Shared types and defaults for the double-buffered line memory.
package line_buf_pkg;

  localparam int unsigned LB_WIDTH = 1;
  localparam int unsigned LB_DEPTH = 480;

  typedef enum logic [1:0] {INIT, IDLE, CLEAR} lb_state_t;

  // Range check done at 32 bits so it stays meaningful when DEPTH is a power of two.
  function automatic logic addr_in_range(input int unsigned addr, input int unsigned depth);
    return addr < depth;
  endfunction

endpackage

// File: rtl/line_buf_bank.sv
// One line bank: single synchronous write port, every entry exposed in parallel.
module line_buf_bank
  import line_buf_pkg::*;
#(
  parameter int unsigned WIDTH = LB_WIDTH,
  parameter int unsigned DEPTH = LB_DEPTH,
  localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   we,
  input  logic [ADDR_W-1:0]      addr,
  input  logic [WIDTH-1:0]       data,
  output logic [DEPTH*WIDTH-1:0] line_flat
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Storage is deliberately unreset; the top's INIT sweep zeroes it.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= data;
    end
  end

  for (genvar i = 0; i < int'(DEPTH); i++) begin : g_flat
    assign line_flat[i*WIDTH +: WIDTH] = mem_q[i];
  end

endmodule

// File: rtl/line_buf_pingpong.sv
// Ping-pong line memory: front bank shown in parallel, back bank written by the
// producer, roles exchanged on swap, plus a sequential clear engine.
module line_buf_pingpong
  import line_buf_pkg::*;
#(
  parameter int unsigned WIDTH = LB_WIDTH,
  parameter int unsigned DEPTH = LB_DEPTH,
  localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  output logic              wr_err,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data,
  output logic [WIDTH-1:0]  line_out [DEPTH],
  input  logic              swap,
  output logic              bank_sel,
  input  logic              clr_req,
  output logic              clr_busy
);

  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

  lb_state_t         state_q, state_d;
  logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
  logic              bank_sel_q, bank_sel_d;
  logic              swap_pend_q, swap_pend_d;
  logic              clr_busy_q, clr_busy_d;
  logic              wr_err_q, wr_err_d;
  logic [WIDTH-1:0]  rd_data_q, rd_data_d;

  logic                   we0, we1;
  logic [ADDR_W-1:0]      bank_addr;
  logic [WIDTH-1:0]       bank_data;
  logic [DEPTH*WIDTH-1:0] bank0_flat, bank1_flat;
  logic                   wr_ok, rd_ok;

  assign wr_ok = addr_in_range(32'(wr_addr), DEPTH);
  assign rd_ok = addr_in_range(32'(rd_addr), DEPTH);

  line_buf_bank #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_bank0 (
    .clk       (clk),
    .we        (we0),
    .addr      (bank_addr),
    .data      (bank_data),
    .line_flat (bank0_flat)
  );

  line_buf_bank #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_bank1 (
    .clk       (clk),
    .we        (we1),
    .addr      (bank_addr),
    .data      (bank_data),
    .line_flat (bank1_flat)
  );

  for (genvar i = 0; i < int'(DEPTH); i++) begin : g_line
    assign line_out[i] = bank_sel_q ? bank1_flat[i*WIDTH +: WIDTH]
                                    : bank0_flat[i*WIDTH +: WIDTH];
  end

  // Bank write mux: INIT zeroes both banks, CLEAR zeroes back, IDLE takes producer writes.
  always_comb begin
    we0       = 1'b0;
    we1       = 1'b0;
    bank_addr = clr_ptr_q;
    bank_data = '0;
    case (state_q)
      INIT: begin
        we0 = 1'b1;
        we1 = 1'b1;
      end
      CLEAR: begin
        we0 = bank_sel_q;
        we1 = ~bank_sel_q;
      end
      IDLE: begin
        if (wr_en && wr_ok) begin
          we0       = bank_sel_q;
          we1       = ~bank_sel_q;
          bank_addr = wr_addr;
          bank_data = wr_data;
        end
      end
      default: ;
    endcase
  end

  // Next-state: clear sequencing, swap handling, read register and error pulse.
  always_comb begin
    state_d     = state_q;
    clr_ptr_d   = clr_ptr_q;
    bank_sel_d  = bank_sel_q;
    swap_pend_d = swap_pend_q;
    clr_busy_d  = clr_busy_q;
    wr_err_d    = wr_en && ((state_q != IDLE) || !wr_ok);
    rd_data_d   = rd_ok ? line_out[rd_addr] : '0;
    case (state_q)
      INIT, CLEAR: begin
        swap_pend_d = swap_pend_q | swap;
        if (clr_ptr_q == LAST_PTR) begin
          state_d    = IDLE;
          clr_ptr_d  = '0;
          clr_busy_d = 1'b0;
        end else begin
          clr_ptr_d = clr_ptr_q + ADDR_W'(1);
        end
      end
      IDLE: begin
        // A swap deferred by a clear lands on the first idle edge; repeats collapse.
        if (swap || swap_pend_q) begin
          bank_sel_d  = ~bank_sel_q;
          swap_pend_d = 1'b0;
        end
        if (clr_req) begin
          state_d    = CLEAR;
          clr_ptr_d  = '0;
          clr_busy_d = 1'b1;
        end
      end
      default: begin
        state_d    = INIT;
        clr_ptr_d  = '0;
        clr_busy_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= INIT;
      clr_ptr_q   <= '0;
      bank_sel_q  <= 1'b0;
      swap_pend_q <= 1'b0;
      clr_busy_q  <= 1'b1;
      wr_err_q    <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      clr_ptr_q   <= clr_ptr_d;
      bank_sel_q  <= bank_sel_d;
      swap_pend_q <= swap_pend_d;
      clr_busy_q  <= clr_busy_d;
      wr_err_q    <= wr_err_d;
      rd_data_q   <= rd_data_d;
    end
  end

  assign wr_err   = wr_err_q;
  assign rd_data  = rd_data_q;
  assign bank_sel = bank_sel_q;
  assign clr_busy = clr_busy_q;

endmodule

// File: tb/tb_line_buf_pingpong.sv
// Directed bench for line_buf_pingpong: an 8x4 instance driven from a vector
// table plus corner sequences, and a default 480x1 instance.
module tb_line_buf_pingpong;

  logic clk;
  int   n_pass  = 0;
  int   n_total = 0;

  // 8 x 4 instance
  logic       rst_a, a_wr_en, a_wr_err, a_swap, a_bank_sel, a_clr_req, a_clr_busy;
  logic [2:0] a_wr_addr, a_rd_addr;
  logic [3:0] a_wr_data, a_rd_data;
  logic [3:0] a_line_out [8];

  // 480 x 1 instance
  logic       rst_b, b_wr_en, b_wr_err, b_swap, b_bank_sel, b_clr_req, b_clr_busy;
  logic [8:0] b_wr_addr, b_rd_addr;
  logic [0:0] b_wr_data, b_rd_data;
  logic [0:0] b_line_out [480];

  line_buf_pingpong #(.WIDTH(4), .DEPTH(8)) dut_a (
    .clk(clk), .rst(rst_a), .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
    .wr_err(a_wr_err), .rd_addr(a_rd_addr), .rd_data(a_rd_data), .line_out(a_line_out),
    .swap(a_swap), .bank_sel(a_bank_sel), .clr_req(a_clr_req), .clr_busy(a_clr_busy)
  );

  line_buf_pingpong dut_b (
    .clk(clk), .rst(rst_b), .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
    .wr_err(b_wr_err), .rd_addr(b_rd_addr), .rd_data(b_rd_data), .line_out(b_line_out),
    .swap(b_swap), .bank_sel(b_bank_sel), .clr_req(b_clr_req), .clr_busy(b_clr_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [3:0]  wr_data;
    logic        swap;
    logic [2:0]  rd_addr;
    logic [31:0] exp_line;
    logic        exp_bank;
    logic [3:0]  exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vecs [9];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Entry i occupies bits [4i+3:4i].
  function automatic logic [31:0] pack_a();
    logic [31:0] p;
    for (int i = 0; i < 8; i++) p[i*4 +: 4] = a_line_out[i];
    return p;
  endfunction

  function automatic int ones_b();
    int c = 0;
    for (int i = 0; i < 480; i++) if (b_line_out[i] !== 1'b0) c++;
    return c;
  endfunction

  task automatic count_busy_a(input int start, output int n);
    n = start;
    while (a_clr_busy === 1'b1 && n < 64) begin
      tick();
      n++;
    end
  endtask

  task automatic count_busy_b(input int start, output int n);
    n = start;
    while (b_clr_busy === 1'b1 && n < 1000) begin
      tick();
      n++;
    end
  endtask

  initial begin
    int n;
    int early;

    //            wr  addr  data  sw   rd    line          bank  rd    err
    vecs[0] = '{1'b1, 3'd3, 4'hA, 1'b0, 3'd3, 32'h0000_0000, 1'b0, 4'h0, 1'b0};
    vecs[1] = '{1'b0, 3'd0, 4'h0, 1'b1, 3'd3, 32'h0000_A000, 1'b1, 4'h0, 1'b0};
    vecs[2] = '{1'b0, 3'd0, 4'h0, 1'b0, 3'd3, 32'h0000_A000, 1'b1, 4'hA, 1'b0};
    vecs[3] = '{1'b1, 3'd5, 4'h7, 1'b1, 3'd3, 32'h0070_0000, 1'b0, 4'hA, 1'b0};
    vecs[4] = '{1'b0, 3'd0, 4'h0, 1'b0, 3'd5, 32'h0070_0000, 1'b0, 4'h7, 1'b0};
    vecs[5] = '{1'b1, 3'd0, 4'h3, 1'b0, 3'd0, 32'h0070_0000, 1'b0, 4'h0, 1'b0};
    vecs[6] = '{1'b0, 3'd0, 4'h0, 1'b1, 3'd0, 32'h0000_A003, 1'b1, 4'h0, 1'b0};
    vecs[7] = '{1'b0, 3'd0, 4'h0, 1'b0, 3'd0, 32'h0000_A003, 1'b1, 4'h3, 1'b0};
    vecs[8] = '{1'b1, 3'd7, 4'hE, 1'b0, 3'd3, 32'h0000_A003, 1'b1, 4'hA, 1'b0};

    rst_a = 1'b0; a_wr_en = 1'b0; a_wr_addr = '0; a_wr_data = '0; a_rd_addr = '0;
    a_swap = 1'b0; a_clr_req = 1'b0;
    rst_b = 1'b0; b_wr_en = 1'b0; b_wr_addr = '0; b_wr_data = '0; b_rd_addr = '0;
    b_swap = 1'b0; b_clr_req = 1'b0;
    tick();
    tick();

    // ---------------- 8 x 4 instance ----------------
    chk("a_rst_busy", a_clr_busy, 1);
    chk("a_rst_bank", a_bank_sel, 0);
    chk("a_rst_rd", a_rd_data, 0);
    chk("a_rst_err", a_wr_err, 0);

    rst_a = 1'b1;
    count_busy_a(0, n);
    chk("a_init_busy_cycles", n, 8);
    chk("a_init_line", pack_a(), 0);
    chk("a_init_bank", a_bank_sel, 0);

    for (int i = 0; i < 9; i++) begin
      a_wr_en   = vecs[i].wr_en;
      a_wr_addr = vecs[i].wr_addr;
      a_wr_data = vecs[i].wr_data;
      a_swap    = vecs[i].swap;
      a_rd_addr = vecs[i].rd_addr;
      tick();
      chk($sformatf("vec%0d_line", i), pack_a(), vecs[i].exp_line);
      chk($sformatf("vec%0d_bank", i), a_bank_sel, vecs[i].exp_bank);
      chk($sformatf("vec%0d_rd", i), a_rd_data, vecs[i].exp_rd);
      chk($sformatf("vec%0d_err", i), a_wr_err, vecs[i].exp_err);
    end
    a_wr_en = 1'b0; a_swap = 1'b0; a_rd_addr = 3'd0;

    // Fill back bank, clear it, with a dropped write on the second clear cycle
    for (int i = 0; i < 8; i++) begin
      a_wr_en = 1'b1; a_wr_addr = 3'(i); a_wr_data = 4'hF;
      tick();
    end
    a_wr_en = 1'b0;
    a_clr_req = 1'b1;
    tick();
    a_clr_req = 1'b0;
    chk("clr_start_busy", a_clr_busy, 1);
    tick();
    a_wr_en = 1'b1; a_wr_addr = 3'd2; a_wr_data = 4'h5;
    tick();
    a_wr_en = 1'b0;
    chk("clr_wr_err_pulse", a_wr_err, 1);
    tick();
    chk("clr_wr_err_single", a_wr_err, 0);
    count_busy_a(3, n);
    chk("clr_busy_cycles", n, 8);
    chk("clr_front_untouched", pack_a(), 32'h0000_A003);
    a_swap = 1'b1;
    tick();
    a_swap = 1'b0;
    chk("clr_swap_bank", a_bank_sel, 0);
    chk("clr_swap_line_zero", pack_a(), 0);

    // Two swap pulses during CLEAR collapse into one deferred toggle
    a_clr_req = 1'b1;
    tick();
    a_clr_req = 1'b0;
    early = 0;
    for (int k = 0; k < 8; k++) begin
      a_swap = (k == 1 || k == 4);
      tick();
      if (a_bank_sel !== 1'b0) early++;
    end
    a_swap = 1'b0;
    chk("pend_no_early_toggle", early, 0);
    chk("pend_clear_done", a_clr_busy, 0);
    tick();
    chk("pend_toggle", a_bank_sel, 1);
    tick();
    chk("pend_single_toggle", a_bank_sel, 1);
    chk("pend_line_zero", pack_a(), 0);

    // Data in both banks, then reset mid-CLEAR
    a_wr_en = 1'b1; a_wr_addr = 3'd1; a_wr_data = 4'h9; a_swap = 1'b1;
    tick();
    a_wr_en = 1'b0; a_swap = 1'b0;
    chk("wrswap_bank", a_bank_sel, 0);
    chk("wrswap_line", pack_a(), 32'h0000_0090);
    a_wr_en = 1'b1; a_wr_addr = 3'd6; a_wr_data = 4'hC;
    tick();
    a_wr_en = 1'b0; a_swap = 1'b1;
    tick();
    a_swap = 1'b0;
    chk("prerst_bank", a_bank_sel, 1);
    chk("prerst_line", pack_a(), 32'h0C00_0000);
    a_clr_req = 1'b1;
    tick();
    a_clr_req = 1'b0;
    tick(); tick(); tick();
    rst_a = 1'b0;
    #1;
    chk("midrst_bank", a_bank_sel, 0);
    chk("midrst_busy", a_clr_busy, 1);
    tick();
    rst_a = 1'b1;
    count_busy_a(0, n);
    chk("rerst_busy_cycles", n, 8);
    chk("rerst_bank", a_bank_sel, 0);
    chk("rerst_line0", pack_a(), 0);
    a_swap = 1'b1;
    tick();
    a_swap = 1'b0;
    chk("rerst_swap_bank", a_bank_sel, 1);
    chk("rerst_line1", pack_a(), 0);

    // ---------------- 480 x 1 instance ----------------
    chk("b_rst_busy", b_clr_busy, 1);
    chk("b_rst_bank", b_bank_sel, 0);
    rst_b = 1'b1;
    count_busy_b(0, n);
    chk("b_init_busy_cycles", n, 480);
    chk("b_init_line", ones_b(), 0);

    b_wr_en = 1'b1; b_wr_addr = 9'd480; b_wr_data = 1'b1;
    tick();
    chk("b_oob480_err", b_wr_err, 1);
    b_wr_addr = 9'd511;
    tick();
    chk("b_oob511_err", b_wr_err, 1);
    b_wr_en = 1'b0;
    tick();
    chk("b_err_clears", b_wr_err, 0);
    b_wr_en = 1'b1; b_wr_addr = 9'd479;
    tick();
    b_wr_en = 1'b0;
    chk("b_last_wr_err", b_wr_err, 0);
    chk("b_back_invisible", ones_b(), 0);
    b_swap = 1'b1;
    tick();
    b_swap = 1'b0;
    chk("b_swap_bank", b_bank_sel, 1);
    chk("b_swap_ones", ones_b(), 1);
    chk("b_swap_last_entry", b_line_out[479], 1);
    b_rd_addr = 9'd479;
    tick();
    chk("b_rd_last", b_rd_data, 1);
    b_rd_addr = 9'd500;
    tick();
    chk("b_rd_oob_zero", b_rd_data, 0);
    b_rd_addr = 9'd479;

    b_wr_en = 1'b1; b_wr_addr = 9'd300;
    tick();
    b_wr_en = 1'b0;
    b_clr_req = 1'b1;
    tick();
    b_clr_req = 1'b0;
    repeat (10) tick();
    chk("b_prerst_rd", b_rd_data, 1);
    rst_b = 1'b0;
    #1;
    chk("b_midrst_bank", b_bank_sel, 0);
    chk("b_midrst_busy", b_clr_busy, 1);
    chk("b_midrst_rd", b_rd_data, 0);
    tick();
    rst_b = 1'b1;
    count_busy_b(0, n);
    chk("b_rerst_busy_cycles", n, 480);
    chk("b_rerst_line0", ones_b(), 0);
    b_swap = 1'b1;
    tick();
    b_swap = 1'b0;
    chk("b_rerst_swap_bank", b_bank_sel, 1);
    chk("b_rerst_line1", ones_b(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
